// File: rtl/v_issue_queue.sv
// v_issue_queue: FIFO issue buffer between the scalar core and the vector coprocessor.
// Optional macro V_ISSUE_PERF_EN adds saturating stall_cycles / issued_count counters.
module v_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        instr_ready,
    output logic [31:0] op_instr_base,
    output logic [31:0] xreg_out1,
    output logic [31:0] xreg_out2,
    input  logic        unit_done,
    output logic        busy,
    output logic        timeout_err,
    output logic [4:0]  q_count
`ifdef V_ISSUE_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] issued_count
`endif
);

    // state | meaning
    // IDLE  | nothing issued; pop head when queue non-empty
    // EXEC  | instruction held on outputs, waiting for unit_done / config / timeout
    // GAP   | one zero cycle so coprocessor enables and done flags drop
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_GAP} state_t;

    localparam int PTR_W = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]         count_q, count_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        x1_q, x1_d;
    logic [31:0]        x2_q, x2_d;
    logic               terr_q, terr_d;

    logic [31:0]        fifo_instr [DEPTH];
    logic [31:0]        fifo_rs1   [DEPTH];
    logic [31:0]        fifo_rs2   [DEPTH];

    logic full, is_vec, is_cfg, push, pop;

    assign full   = (count_q == 5'(DEPTH));
    assign is_vec = (instr_in[6:0] == 7'b1010111) || (instr_in[6:0] == 7'b0000111) ||
                    (instr_in[6:0] == 7'b0100111);
    assign is_cfg = (instr_q[6:0] == 7'b1010111) && (instr_q[14:12] == 3'b111);
    // Non-vector instructions are handshaken but never stored.
    assign push   = instr_valid && !full && is_vec;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        terr_d   = terr_q;
        pop      = 1'b0;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        case (state_q)
            S_IDLE: begin
                if (count_q != 5'd0) begin
                    pop      = 1'b1;
                    instr_d  = fifo_instr[rd_ptr_q];
                    x1_d     = fifo_rs1[rd_ptr_q];
                    x2_d     = fifo_rs2[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + 8'd1;
                if (unit_done || is_cfg || (cnt_d == 8'(TIMEOUT))) begin
                    state_d = S_GAP;
                    instr_d = '0;
                    x1_d    = '0;
                    x2_d    = '0;
                    // A done coinciding with the timeout counts as a normal retire.
                    if (!unit_done && !is_cfg) terr_d = 1'b1;
                end
            end
            S_GAP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        count_d = count_q + {4'd0, push} - {4'd0, pop};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            terr_q   <= terr_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= instr_in;
            fifo_rs1[wr_ptr_q]   <= rs1_data;
            fifo_rs2[wr_ptr_q]   <= rs2_data;
        end
    end

    assign instr_ready   = !full;
    assign op_instr_base = instr_q;
    assign xreg_out1     = x1_q;
    assign xreg_out2     = x2_q;
    assign busy          = (state_q != S_IDLE) || (count_q != 5'd0);
    assign timeout_err   = terr_q;
    assign q_count       = count_q;

`ifdef V_ISSUE_PERF_EN
    logic [31:0] stall_q, stall_d, issued_q, issued_d;

    always_comb begin
        stall_d  = stall_q;
        issued_d = issued_q;
        if (instr_valid && full && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (pop && (issued_q != '1)) issued_d = issued_q + 32'd1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_q  <= '0;
            issued_q <= '0;
        end else begin
            stall_q  <= stall_d;
            issued_q <= issued_d;
        end
    end

    assign stall_cycles = stall_q;
    assign issued_count = issued_q;
`endif

endmodule
